simple_axi_write_burster: RTL
=============================

# simple_axi_write_burster

Parametrised bridge from the single-request "simple" write interface to a full AXI4 write master. A request of N bytes at an aligned address is split into legal INCR bursts, capped by `MAX_BURST` and by 4 KB boundaries, and streamed beat by beat from the simple side. It generalises data width, byte-granular length with a partial final strobe, and adds write-response error reporting and a completion pulse. It sits between accelerator write units and the system interconnect.

## Interface
- `AXI_ADDR_W`, 32, address width.
- `AXI_DATA_W`, 32, data width; one of 32, 64 or 128. `BYTES = AXI_DATA_W/8`.
- `AXI_LEN_W`, 8, width of the AXI len field.
- `AXI_ID_W`, 1, ID width; `awid` is constant 0.
- `LEN_W`, 16, width of the request byte length.
- `MAX_BURST`, 256, maximum beats per burst; a power of 2 with `MAX_BURST ≤ 2^AXI_LEN_W`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m_wvalid_i` in 1: request present / data beat valid.
- `m_wready_o` out 1: data beat accepted.
- `m_waddr_i` in AXI_ADDR_W: start address; low log2(BYTES) bits must be zero.
- `m_wdata_i` in AXI_DATA_W: beat data.
- `m_wstrb_i` in BYTES: beat strobe; ANDed with the computed strobe.
- `m_wlen_i` in LEN_W: request length in bytes.
- `m_wlast_o` out 1: current beat is the final beat of the whole request.
- `done_o` out 1: one-cycle pulse when the request completes.
- `err_o` out 1: at least one burst of the last request returned `bresp != OKAY`.
- `axi_aw*`: id, addr, len, size, burst, lock, cache, prot, qos, valid (out); ready (in).
- `axi_w*`: data, strb, last, valid (out); ready (in).
- `axi_b*`: id, resp, valid (in); ready (out).

## Operation
- **Constants:** `awsize = log2(BYTES)`, `awburst = INCR`, lock/cache/prot/qos = 0.
- **IDLE:** on `m_wvalid_i`, latch `addr = m_waddr_i`, `rem_bytes = m_wlen_i`, `rem_beats = ceil(m_wlen_i/BYTES)`, and clear `err`.
  - If `m_wlen_i == 0`, pulse `done_o` and stay in IDLE. No AXI activity occurs and `m_wready_o` stays 0.
  - Otherwise go to CALC.
- **CALC:** `beats = min(rem_beats, MAX_BURST, (4096 − addr[11:0])/BYTES)`. Register `awlen = beats − 1`, set `awvalid = 1`, go to AW.
- **AW:** hold addr/len/valid stable until `awready`. On handshake:
  - clear `awvalid`, clear the beat counter, go to W;
  - pre-compute next `addr += beats·BYTES`.
- **W:** pure pass-through.
  - `axi_wvalid_o = m_wvalid_i`, `m_wready_o = axi_wready_i`, `axi_wdata_o = m_wdata_i`.
  - `axi_wlast_o` is asserted when beat counter == `awlen`.
  - `m_wlast_o` is asserted when `rem_beats == 1`.
  - Strobe is all ones, except on the request's final beat: `(1 << (m_wlen mod BYTES)) − 1`, or all ones if the remainder is 0. The result is ANDed with `m_wstrb_i`.
  - Each handshake decrements `rem_beats`. On the burst's last beat, set `bready = 1` and go to B.
- **B:** on `bvalid`: `bready ← 0`, `err |= (bresp != 0)`.
  - If `rem_beats == 0`, pulse `done_o` and go to IDLE.
  - Otherwise go to CALC.
- Outside W, `axi_wvalid_o`, `m_wready_o`, `m_wlast_o` and `axi_wlast_o` are all 0.
- An error does not abort the request; the remaining bursts are still issued.
- `err_o` holds its value until the next request is accepted.

## Timing
- **Reset values:** all outputs 0 (awvalid, awaddr, awlen, wvalid, wlast, wstrb, bready, m_wready, m_wlast, done, err); state is IDLE.
- **Latency:** request in IDLE → `awvalid` high 2 cycles later (IDLE→CALC→AW registered).
- **Inter-burst gap:** B→CALC→AW gives one dead cycle between bursts.
- **Data path:** zero added latency in W (combinational).
- **Completion:** `done_o` is asserted in the cycle after the final `bvalid`/`bready` handshake.
- **AXI stability:** `awvalid` never deasserts before `awready`. `awaddr`/`awlen` do not change while `awvalid` is high.
- **Beats per burst:** exactly `awlen + 1` handshakes; `wlast` appears on the final one only.
- **Simultaneous `awready` with entry to AW:** the handshake completes in that cycle.
- **Reset mid-transfer:** outputs drop asynchronously; no state is retained.
- **Simple-side protocol:** the master holds `m_waddr_i`/`m_wlen_i` only in the IDLE accept cycle; `m_wvalid_i` may gap freely in W.

## Test plan
- **Single burst:** DATA_W=32, addr 0x1000, len 16 → one burst: awaddr 0x1000, awlen 3, awsize 2; strb 0xF×4; wlast and m_wlast on beat 4; done 1 cycle after B.
- **MAX_BURST split:** DATA_W=32, addr 0x0, len 1030 → burst awaddr 0x0 awlen 255, then burst awaddr 0x400 awlen 1; final strb 0x3; m_wlast only on beat 258.
- **4 KB split:** addr 0x0FF0, len 64 → burst 0x0FF0 awlen 3, then burst 0x1000 awlen 11; no burst crosses 0x1000.
- **Wide data:** DATA_W=64, addr 0x20, len 13, m_wstrb all ones → awsize 3, awlen 1, strb 0xFF then 0x1F.
- **Error reporting:** two-burst request, first bresp SLVERR, second OKAY → second burst still issued; done with err_o=1; next request clears err_o to 0 on accept.
- **Backpressure and reset:**
  - Random wready, awready and m_wvalid gaps → data order preserved, no dropped or duplicated beats.
  - len 0 → done pulse only, no AXI activity.
  - rst_i in mid-W → all outputs 0 immediately.

Source files
------------

// File: rtl/simple_axi_write_burster.sv
// Bridges a single simple write request (addr, byte length, streamed beats) onto AXI4
// INCR bursts limited by MAX_BURST and 4 KB pages; W data passes through combinationally.
module simple_axi_write_burster #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m_wvalid_i,
  output logic                    m_wready_o,
  input  logic [AXI_ADDR_W-1:0]   m_waddr_i,
  input  logic [AXI_DATA_W-1:0]   m_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] m_wstrb_i,
  input  logic [LEN_W-1:0]        m_wlen_i,
  output logic                    m_wlast_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic                    axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [2:0]              axi_awprot_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [AXI_ID_W-1:0]     axi_bid_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);
  localparam int BYTES = AXI_DATA_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int RB_W  = LEN_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_t;
  state_t state_q, state_d;

  logic [AXI_ADDR_W-1:0] addr_q;
  logic [RB_W-1:0]       rem_beats_q;
  logic [SH-1:0]         len_mod_q;
  logic [AXI_LEN_W-1:0]  awlen_q, beat_q;
  logic                  awvalid_q, bready_q, done_q, err_q;

  logic        in_w, w_hs, last_in_burst, final_beat;
  logic [31:0] page_beats, beats_c;
  logic [BYTES-1:0] tail_strb;

  assign in_w          = (state_q == S_W);
  assign w_hs          = in_w && m_wvalid_i && axi_wready_i;
  assign last_in_burst = (beat_q == awlen_q);
  assign final_beat    = (rem_beats_q == RB_W'(1));

  // Burst size is the smallest of what is left, the burst cap and the room to the page end
  always_comb begin
    page_beats = (32'd4096 - 32'(addr_q[11:0])) >> SH;
    beats_c    = 32'(rem_beats_q);
    if (beats_c > 32'(MAX_BURST)) beats_c = 32'(MAX_BURST);
    if (beats_c > page_beats)     beats_c = page_beats;
  end

  always_comb begin
    tail_strb = '0;
    for (int i = 0; i < BYTES; i++)
      tail_strb[i] = (len_mod_q == '0) || (SH'(i) < len_mod_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (m_wvalid_i && (m_wlen_i != '0)) state_d = S_CALC;
      S_CALC:  state_d = S_AW;
      S_AW:    if (axi_awready_i) state_d = S_W;
      S_W:     if (w_hs && last_in_burst) state_d = S_B;
      S_B:     if (axi_bvalid_i) state_d = (rem_beats_q == '0) ? S_IDLE : S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      rem_beats_q <= '0;
      len_mod_q   <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (m_wvalid_i) begin
          addr_q      <= m_waddr_i;
          rem_beats_q <= (RB_W'(m_wlen_i) + RB_W'(BYTES - 1)) >> SH;
          len_mod_q   <= m_wlen_i[SH-1:0];
          err_q       <= 1'b0;
          if (m_wlen_i == '0) done_q <= 1'b1;
        end
        S_CALC: begin
          awlen_q   <= AXI_LEN_W'(beats_c - 32'd1);
          awvalid_q <= 1'b1;
        end
        S_AW: if (axi_awready_i) begin
          awvalid_q <= 1'b0;
          beat_q    <= '0;
          addr_q    <= addr_q + AXI_ADDR_W'((32'(awlen_q) + 32'd1) << SH);
        end
        S_W: if (w_hs) begin
          rem_beats_q <= rem_beats_q - RB_W'(1);
          beat_q      <= beat_q + AXI_LEN_W'(1);
          if (last_in_burst) bready_q <= 1'b1;
        end
        S_B: if (axi_bvalid_i) begin
          bready_q <= 1'b0;
          err_q    <= err_q | (axi_bresp_i != 2'b00);
          if (rem_beats_q == '0) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign axi_awid_o    = '0;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = 3'(SH);
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 1'b0;
  assign axi_awcache_o = 4'd0;
  assign axi_awprot_o  = 3'd0;
  assign axi_awqos_o   = 4'd0;
  assign axi_awvalid_o = awvalid_q;

  assign axi_wdata_o   = m_wdata_i;
  assign axi_wvalid_o  = in_w && m_wvalid_i;
  assign m_wready_o    = in_w && axi_wready_i;
  assign axi_wlast_o   = in_w && last_in_burst;
  assign m_wlast_o     = in_w && final_beat;
  assign axi_wstrb_o   = in_w ? (m_wstrb_i & (final_beat ? tail_strb : {BYTES{1'b1}})) : '0;

  assign axi_bready_o  = bready_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

  logic unused_bid;
  assign unused_bid = ^axi_bid_i;
endmodule
